// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one byte-wide UART transmitter between
//   NUM_REQ byte producers. Each frame it captures the winning byte, strobes
//   tx_en for EN_PULSE cycles, waits for tx_done (bounded by a watchdog), then
//   idles GAP_CYCLES cycles before arbitrating again.
//
//   Optional build macro: UART_ARB_LOCK_EN
//     Adds req_last. A transfer with req_last = 0 locks the next grant to the
//     same requester, so multi-byte packets are never interleaved.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   req_valid     per-requester byte pending
//   req_data      requester i byte at [8i+7:8i]
//   req_last      (UART_ARB_LOCK_EN only) last byte of a locked packet
//   req_ready     one-hot accept strobe, combinational, only in IDLE
//   tx_en         transmitter start strobe (high EN_PULSE cycles)
//   tx_data       byte to transmit, held until the next transfer
//   tx_done       transmitter end-of-frame pulse
//   busy          state is not IDLE
//   grant_id      index of the requester whose byte is in flight
//   byte_sent     one-cycle pulse when tx_done is accepted
//   timeout_err   one-cycle pulse when the watchdog expires
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned EN_PULSE       = 2,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 8192
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   req_last,
`endif
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_en,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 byte_sent,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    GAP
  } state_t;

  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [15:0]     EN_LAST   = 16'(EN_PULSE - 1);
  localparam logic [15:0]     GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0]     WD_LAST   = 16'(TIMEOUT_CYCLES - 1);

  state_t          state, state_d;
  logic [ID_W-1:0] ptr, ptr_d;
  logic [ID_W-1:0] winner, winner_next;
  logic            found;
  logic [ID_W:0]   cand_sum;
  logic [ID_W-1:0] cand;
  logic [7:0]      sel_data;
  logic [15:0]     cnt, cnt_d;
  logic            tx_en_d;
  logic [7:0]      tx_data_d;
  logic [ID_W-1:0] grant_id_d;
  logic            byte_sent_d;
  logic            timeout_err_d;
`ifdef UART_ARB_LOCK_EN
  logic            lock_q, lock_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;
`endif

  // Round-robin search from ptr upward, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand_sum = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand_sum >= NUM_REQ_W) cand_sum = cand_sum - NUM_REQ_W;
      cand = cand_sum[ID_W-1:0];
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`ifdef UART_ARB_LOCK_EN
    // A locked packet overrides the search: only its owner may be served.
    if (lock_q) begin
      found  = req_valid[lock_id_q];
      winner = lock_id_q;
    end
`endif
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) sel_data = req_data[8*i +: 8];
    end
  end

  assign winner_next = (winner == LAST_ID) ? '0 : winner + 1'b1;

  assign req_ready = (state == IDLE && found && !rst)
                     ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner) : '0;

  assign busy = (state != IDLE);

  // One counter serves START (pulse length), WAIT_DONE (watchdog) and GAP,
  // since those states are mutually exclusive; it is cleared on every entry.
  always_comb begin
    state_d       = state;
    ptr_d         = ptr;
    cnt_d         = cnt;
    tx_en_d       = tx_en;
    tx_data_d     = tx_data;
    grant_id_d    = grant_id;
    byte_sent_d   = 1'b0;
    timeout_err_d = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock_d        = lock_q;
    lock_id_d     = lock_id_q;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          tx_data_d  = sel_data;
          grant_id_d = winner;
          tx_en_d    = 1'b1;
          cnt_d      = '0;
          state_d    = START;
`ifdef UART_ARB_LOCK_EN
          if (req_last[winner]) begin
            lock_d = 1'b0;
            ptr_d  = winner_next;
          end else begin
            lock_d    = 1'b1;
            lock_id_d = winner;
          end
`else
          ptr_d = winner_next;
`endif
        end
      end
      START: begin
        if (cnt == EN_LAST) begin
          tx_en_d = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      WAIT_DONE: begin
        if (tx_done || (TIMEOUT_CYCLES != 0 && cnt == WD_LAST)) begin
          // tx_done has priority over a simultaneous watchdog expiry.
          byte_sent_d   = tx_done;
          timeout_err_d = !tx_done;
          cnt_d         = '0;
          state_d       = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        tx_en_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      tx_en       <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= '0;
      byte_sent   <= 1'b0;
      timeout_err <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
`endif
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      cnt         <= cnt_d;
      tx_en       <= tx_en_d;
      tx_data     <= tx_data_d;
      grant_id    <= grant_id_d;
      byte_sent   <= byte_sent_d;
      timeout_err <= timeout_err_d;
`ifdef UART_ARB_LOCK_EN
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Expected frames ({grant, byte}) are
// queued as stimulus is driven and compared when tx_en rises.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ        = 4;
  localparam int unsigned ID_W           = 2;
  localparam int unsigned EN_PULSE       = 2;
  localparam int unsigned GAP_CYCLES     = 4;
  localparam int unsigned TIMEOUT_CYCLES = 64;
`ifdef UART_ARB_LOCK_EN
  localparam int EXP_BYTES = 14;
`else
  localparam int EXP_BYTES = 10;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
  logic [NUM_REQ-1:0]   req_last;
`endif
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_en;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;
  logic                 byte_sent;
  logic                 timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W(ID_W),
    .EN_PULSE(EN_PULSE),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
`ifdef UART_ARB_LOCK_EN
    .req_last(req_last),
`endif
    .req_ready(req_ready),
    .tx_en(tx_en),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .busy(busy),
    .grant_id(grant_id),
    .byte_sent(byte_sent),
    .timeout_err(timeout_err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          bs_count = 0;
  int          to_count = 0;
  int          bs_mark;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  logic        tx_en_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_en_rise(input string tag);
    int k = 0;
    while (tx_en !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    chk({tag, "_en_rise"}, 32'(tx_en), 32'd1);
  endtask

  task automatic finish_frame(input int delay, input string tag);
    int k = 0;
    while (tx_en !== 1'b0 && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_en_fall"}, 32'(tx_en), 32'd0);
    step(delay);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk({tag, "_byte_sent"}, 32'(byte_sent), 32'd1);
  endtask

  // Monitor: pulse counters, ready-only-in-IDLE, scoreboard pop on tx_en rise.
  always @(negedge clk) begin
    if (byte_sent === 1'b1) bs_count++;
    if (timeout_err === 1'b1) to_count++;
    if (busy === 1'b1) chk("ready_outside_idle", 32'(req_ready), 32'd0);
    if (tx_en === 1'b1 && tx_en_prev === 1'b0) begin
      chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("frame_grant", 32'(grant_id), 32'(mon_e[15:8]));
        chk("frame_data", 32'(tx_data), 32'(mon_e[7:0]));
      end
    end
    tx_en_prev = tx_en;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_done   = 1'b0;
`ifdef UART_ARB_LOCK_EN
    req_last  = '1;
`endif
    step(3);

    // Reset state, with requests present while rst is high.
    req_valid = 4'hF;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_byte_sent", 32'(byte_sent), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    req_valid = '0;
    step();
    rst = 1'b0;
    step();

    // Single requester 2, tx_done ignored in START and GAP.
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    exp_q.push_back({8'd2, 8'hA5});
    #1;
    chk("t1_ready", 32'(req_ready), 32'h4);
    step();
    chk("t1_tx_en_s0", 32'(tx_en), 32'd1);
    chk("t1_tx_data", 32'(tx_data), 32'hA5);
    chk("t1_grant", 32'(grant_id), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready_start", 32'(req_ready), 32'd0);
    req_valid = '0;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("t1_tx_en_s1", 32'(tx_en), 32'd1);
    chk("t1_done_in_start", 32'(byte_sent), 32'd0);
    step();
    chk("t1_tx_en_wait", 32'(tx_en), 32'd0);
    chk("t1_busy_wait", 32'(busy), 32'd1);
    step(19);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("t1_byte_sent", 32'(byte_sent), 32'd1);
    chk("t1_data_hold", 32'(tx_data), 32'hA5);
    step();
    chk("t1_bs_pulse", 32'(byte_sent), 32'd0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("t1_done_in_gap", 32'(byte_sent), 32'd0);
    chk("t1_busy_gap", 32'(busy), 32'd1);
    step();
    chk("t1_busy_g3", 32'(busy), 32'd1);
    step();
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_grant_hold", 32'(grant_id), 32'd2);

    // Round robin from pointer 0 with all four continuously valid.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    req_data  = 32'h13121110;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) exp_q.push_back({8'(k % 4), 8'(8'h10 + (k % 4))});
    for (int k = 0; k < 5; k++) begin
      wait_en_rise("t2");
      finish_frame(3, "t2");
    end
    req_valid = '0;
    step(6);
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Watchdog expiry, then the pending requester 3 is served.
    req_valid = 4'b0010;
    exp_q.push_back({8'd1, 8'h11});
    wait_en_rise("t3");
    req_valid = 4'b1000;
    exp_q.push_back({8'd3, 8'h13});
    bs_mark = bs_count;
    step(2);
    chk("t3_wait_entry", 32'(tx_en), 32'd0);
    step(63);
    chk("t3_no_timeout_yet", 32'(timeout_err), 32'd0);
    step();
    chk("t3_timeout", 32'(timeout_err), 32'd1);
    chk("t3_no_byte_sent", 32'(byte_sent), 32'd0);
    step();
    chk("t3_timeout_pulse", 32'(timeout_err), 32'd0);
    wait_en_rise("t3b");
    req_valid = '0;
    finish_frame(2, "t3b");
    step(6);
    chk("t3_timeout_count", 32'(to_count), 32'd1);
    chk("t3_bs_count", 32'(bs_count - bs_mark), 32'd1);

    // tx_done coinciding with watchdog expiry: byte_sent only.
    req_valid = 4'b0001;
    exp_q.push_back({8'd0, 8'h10});
    wait_en_rise("t4");
    req_valid = '0;
    step(2);
    step(63);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("t4_byte_sent", 32'(byte_sent), 32'd1);
    chk("t4_no_timeout", 32'(timeout_err), 32'd0);
    step(4);
    chk("t4_idle", 32'(busy), 32'd0);

    // Reset during WAIT_DONE of requester 3, then 1 wins over 3.
    req_valid = 4'b1000;
    exp_q.push_back({8'd3, 8'h13});
    wait_en_rise("t5");
    req_valid = 4'b1010;
    step(2);
    step(5);
    rst = 1'b1;
    #1;
    chk("t5_rst_tx_en", 32'(tx_en), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    chk("t5_rst_grant", 32'(grant_id), 32'd0);
    chk("t5_rst_data", 32'(tx_data), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("t5_ready_after_rst", 32'(req_ready), 32'h2);
    exp_q.push_back({8'd1, 8'h11});
    exp_q.push_back({8'd3, 8'h13});
    wait_en_rise("t5a");
    req_valid = 4'b1000;
    finish_frame(1, "t5a");
    wait_en_rise("t5b");
    req_valid = '0;
    finish_frame(1, "t5b");
    step(6);

`ifdef UART_ARB_LOCK_EN
    // Locked 3-byte packet from requester 0 while requester 1 waits.
    req_data  = 32'h0000D1C0;
    req_last  = 4'b1110;
    req_valid = 4'b0011;
    exp_q.push_back({8'd0, 8'hC0});
    exp_q.push_back({8'd0, 8'hC1});
    exp_q.push_back({8'd0, 8'hC2});
    exp_q.push_back({8'd1, 8'hD1});
    for (int k = 0; k < 3; k++) begin
      wait_en_rise("lock");
      if (k < 2) begin
        req_data[7:0] = 8'(8'hC1 + k);
        req_last[0]   = (k == 1);
      end else begin
        req_valid[0] = 1'b0;
      end
      finish_frame(1, "lock");
    end
    wait_en_rise("lock_r1");
    req_valid = '0;
    finish_frame(1, "lock_r1");
    step(6);
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_byte_count", 32'(bs_count), 32'(EXP_BYTES));
    chk("final_timeout_count", 32'(to_count), 32'd1);
    chk("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
